// File: rtl/reg_file_pkg.sv
// Shared widths and types for the ALU-side register file.
// Consumers pull these in with import reg_file_pkg::*.
package reg_file_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_read_port.sv
// One registered read port: selects a register and loads it into the output flop on rd_en (1-cycle latency).
// REG_FILE_BYPASS_EN: a same-edge write to the read address forwards wr_data instead of the old contents.
module reg_read_port
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      rd_en,
  input  reg_addr_t rd_addr,
  input  reg_data_t regs [NUM_REGS],
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_data_t wr_data,
  output reg_data_t out_dat
);

  reg_data_t out_q;
  reg_data_t out_d;
  logic      wr_hit;

  assign wr_hit = wr_en && (wr_addr == rd_addr);

`ifdef REG_FILE_BYPASS_EN
  always_comb begin
    out_d = out_q;
    if (rd_en) begin
      out_d = wr_hit ? wr_data : regs[rd_addr];
    end
  end
`else
  // Without forwarding the port sees the pre-write array; the hit is left unused.
  logic unused_wr_hit;
  assign unused_wr_hit = ^{wr_hit, wr_data};

  always_comb begin
    out_d = out_q;
    if (rd_en) begin
      out_d = regs[rd_addr];
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out_dat = out_q;

endmodule

// File: rtl/reg_file.sv
// 8x8 register file feeding the ALU: registered reads (1 cycle), write of ALU result and carry at the edge.
// REG_FILE_BYPASS_EN selects write-to-read forwarding on same-edge address matches.
module reg_file
  import reg_file_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN,
  input  logic              CO_IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  input  logic              READ_EN,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic              CARRY,
  output logic              OUT_VALID
);

  reg_data_t regs_q [NUM_REGS];
  reg_data_t regs_d [NUM_REGS];
  logic      carry_q;
  logic      carry_d;
  logic      out_valid_q;
  logic      out_valid_d;

  always_comb begin
    regs_d = regs_q;
    carry_d = carry_q;
    if (WRITE) begin
      regs_d[INADDRESS] = IN;
      carry_d = CO_IN;
    end
    out_valid_d = READ_EN;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  reg_read_port u_rd1 (
    .clk     (CLK),
    .rst     (RESET),
    .rd_en   (READ_EN),
    .rd_addr (OUT1ADDRESS),
    .regs    (regs_q),
    .wr_en   (WRITE),
    .wr_addr (INADDRESS),
    .wr_data (IN),
    .out_dat (OUT1)
  );

  reg_read_port u_rd2 (
    .clk     (CLK),
    .rst     (RESET),
    .rd_en   (READ_EN),
    .rd_addr (OUT2ADDRESS),
    .regs    (regs_q),
    .wr_en   (WRITE),
    .wr_addr (INADDRESS),
    .wr_data (IN),
    .out_dat (OUT2)
  );

  assign CARRY     = carry_q;
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, mid-cycle reset, then random traffic vs a model.
module tb_reg_file;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] IN = '0;
  logic       CO_IN = 1'b0;
  logic [2:0] INADDRESS = '0;
  logic       WRITE = 1'b0;
  logic [2:0] OUT1ADDRESS = '0;
  logic [2:0] OUT2ADDRESS = '0;
  logic       READ_EN = 1'b0;
  logic [7:0] OUT1;
  logic [7:0] OUT2;
  logic       CARRY;
  logic       OUT_VALID;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN          (IN),
    .CO_IN       (CO_IN),
    .INADDRESS   (INADDRESS),
    .WRITE       (WRITE),
    .OUT1ADDRESS (OUT1ADDRESS),
    .OUT2ADDRESS (OUT2ADDRESS),
    .READ_EN     (READ_EN),
    .OUT1        (OUT1),
    .OUT2        (OUT2),
    .CARRY       (CARRY),
    .OUT_VALID   (OUT_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       co;
    logic       re;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] e_o1;
    logic [7:0] e_o2;
    logic       e_c;
    logic       e_v;
  } vec_t;

  vec_t vecs[$];

  int total = 0;
  int bad = 0;

  // Reference model: plain array plus the visible output state.
  logic [7:0] m_mem [8];
  logic [7:0] m_o1, m_o2;
  logic       m_c, m_v;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    m_o1 = 8'h00; m_o2 = 8'h00; m_c = 1'b0; m_v = 1'b0;
  endtask

  task automatic model_step(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                            input logic co, input logic re, input logic [2:0] a1, input logic [2:0] a2);
    if (re) begin
      m_o1 = (BYP && we && a1 == wa) ? wd : m_mem[a1];
      m_o2 = (BYP && we && a2 == wa) ? wd : m_mem[a2];
    end
    m_v = re;
    if (we) begin
      m_mem[wa] = wd;
      m_c = co;
    end
  endtask

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got {o1,o2,c,v}=%h want=%h", nm, act, exp);
    end
  endtask

  // Drives one cycle of inputs; returns at posedge+1 for sampling.
  task automatic cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                     input logic co, input logic re, input logic [2:0] a1, input logic [2:0] a2);
    WRITE = we; INADDRESS = wa; IN = wd; CO_IN = co;
    READ_EN = re; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
    @(posedge CLK);
    #1;
    model_step(we, wa, wd, co, re, a1, a2);
  endtask

  task automatic add(input logic we, input logic [2:0] wa, input logic [7:0] wd, input logic co,
                     input logic re, input logic [2:0] a1, input logic [2:0] a2,
                     input logic [7:0] o1, input logic [7:0] o2, input logic c, input logic v);
    vec_t t;
    t.we = we; t.wa = wa; t.wd = wd; t.co = co; t.re = re; t.a1 = a1; t.a2 = a2;
    t.e_o1 = o1; t.e_o2 = o2; t.e_c = c; t.e_v = v;
    vecs.push_back(t);
  endtask

  initial begin
    logic [7:0] hz;
    logic [7:0] v8;
    hz = BYP ? 8'hAA : 8'h10;

    // Write/read, carry capture, hazard, hold, then full sweep.
    add(1, 3'd1, 8'h03, 0, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0);
    add(1, 3'd2, 8'h04, 0, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0);
    add(0, 3'd0, 8'h00, 0, 1, 3'd1, 3'd2, 8'h03, 8'h04, 0, 1);
    add(1, 3'd3, 8'h07, 1, 0, 3'd0, 3'd0, 8'h03, 8'h04, 1, 0);
    add(1, 3'd4, 8'h08, 0, 0, 3'd0, 3'd0, 8'h03, 8'h04, 0, 0);
    add(0, 3'd4, 8'h99, 1, 0, 3'd0, 3'd0, 8'h03, 8'h04, 0, 0);
    add(1, 3'd5, 8'h10, 0, 0, 3'd0, 3'd0, 8'h03, 8'h04, 0, 0);
    add(1, 3'd5, 8'hAA, 0, 1, 3'd5, 3'd5, hz,    hz,    0, 1);
    add(0, 3'd0, 8'h00, 0, 1, 3'd5, 3'd5, 8'hAA, 8'hAA, 0, 1);
    add(1, 3'd5, 8'h11, 0, 0, 3'd5, 3'd5, 8'hAA, 8'hAA, 0, 0);
    add(1, 3'd5, 8'h22, 0, 0, 3'd5, 3'd5, 8'hAA, 8'hAA, 0, 0);
    add(1, 3'd5, 8'h33, 0, 0, 3'd5, 3'd5, 8'hAA, 8'hAA, 0, 0);
    add(0, 3'd0, 8'h00, 0, 1, 3'd5, 3'd3, 8'h33, 8'h07, 0, 1);
    for (int i = 0; i < 8; i++) begin
      v8 = 8'hF0 + 8'(i);
      add(1, 3'(i), v8, 0, 0, 3'd0, 3'd0, 8'h33, 8'h07, 0, 0);
    end
    for (int i = 0; i < 8; i++) begin
      add(0, 3'd0, 8'h00, 0, 1, 3'(i), 3'(7 - i), 8'hF0 + 8'(i), 8'hF7 - 8'(i), 0, 1);
    end

    model_reset();
    @(posedge CLK); #1;
    check("reset_hold", {OUT1, OUT2, CARRY, OUT_VALID}, 18'h0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    check("post_reset", {OUT1, OUT2, CARRY, OUT_VALID}, 18'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].co, vecs[i].re, vecs[i].a1, vecs[i].a2);
      check($sformatf("vec%0d", i), {OUT1, OUT2, CARRY, OUT_VALID},
            {vecs[i].e_o1, vecs[i].e_o2, vecs[i].e_c, vecs[i].e_v});
    end

    // Mid-cycle asynchronous reset with a write and read pending.
    cyc(1, 3'd2, 8'h55, 1, 1, 3'd6, 3'd1);
    check("pre_reset", {OUT1, OUT2, CARRY, OUT_VALID}, {8'hF6, 8'hF1, 1'b1, 1'b1});
    WRITE = 1'b1; INADDRESS = 3'd4; IN = 8'h77; CO_IN = 1'b1; READ_EN = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    check("async_reset", {OUT1, OUT2, CARRY, OUT_VALID}, 18'h0);
    @(posedge CLK); #1;
    check("reset_held", {OUT1, OUT2, CARRY, OUT_VALID}, 18'h0);
    WRITE = 1'b0; READ_EN = 1'b0;
    RESET = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(0, 3'd0, 8'h00, 0, 1, 3'(i), 3'(7 - i));
      check($sformatf("reset_rd%0d", i), {OUT1, OUT2, CARRY, OUT_VALID}, {8'h00, 8'h00, 1'b0, 1'b1});
    end

    // Random traffic against the model; small address range raises hazard rate.
    for (int n = 0; n < 400; n++) begin
      logic       we, co, re;
      logic [2:0] wa, a1, a2;
      logic [7:0] wd;
      we = 1'($urandom_range(0, 1));
      co = 1'($urandom_range(0, 1));
      re = ($urandom_range(0, 3) != 0);
      wa = 3'($urandom_range(0, 7));
      a1 = (n % 4 == 0) ? wa : 3'($urandom_range(0, 7));
      a2 = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      cyc(we, wa, wd, co, re, a1, a2);
      check($sformatf("rand%0d", n), {OUT1, OUT2, CARRY, OUT_VALID}, {m_o1, m_o2, m_c, m_v});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
